// File: rtl/systolic_pe_sat_if.sv
// Systolic PE port bundle: weight chain, ifmap/psum datapath and overflow status.
// slave is the PE's view, master is the neighbour/driver view.
interface systolic_pe_sat_if #(
  parameter int unsigned IFMAP_W = 16,
  parameter int unsigned W_W     = 8,
  parameter int unsigned PSUM_W  = 32
);
  logic               w_load_in;
  logic [W_W-1:0]     w_data_in;
  logic               w_swap_in;
  logic               w_load_out;
  logic [W_W-1:0]     w_data_out;
  logic               w_swap_out;
  logic               ifmap_valid_in;
  logic [IFMAP_W-1:0] ifmap_data_in;
  logic [PSUM_W-1:0]  psum_data_in;
  logic               ifmap_valid_out;
  logic [IFMAP_W-1:0] ifmap_data_out;
  logic               psum_valid_out;
  logic [PSUM_W-1:0]  psum_data_out;
  logic               clr_ovf;
  logic               ovf_sticky;
  logic               nw_err;

  modport slave (
    input  w_load_in, w_data_in, w_swap_in, ifmap_valid_in, ifmap_data_in,
           psum_data_in, clr_ovf,
    output w_load_out, w_data_out, w_swap_out, ifmap_valid_out, ifmap_data_out,
           psum_valid_out, psum_data_out, ovf_sticky, nw_err
  );

  modport master (
    output w_load_in, w_data_in, w_swap_in, ifmap_valid_in, ifmap_data_in,
           psum_data_in, clr_ovf,
    input  w_load_out, w_data_out, w_swap_out, ifmap_valid_out, ifmap_data_out,
           psum_valid_out, psum_data_out, ovf_sticky, nw_err
  );
endinterface

// File: rtl/systolic_pe_sat.sv
// Weight-stationary systolic PE with double-buffered weight, psum valid and
// saturating or wrapping accumulate with a sticky overflow flag.
module systolic_pe_sat #(
  parameter int unsigned IFMAP_W  = 16,
  parameter int unsigned W_W      = 8,
  parameter int unsigned PSUM_W   = 32,
  parameter bit          SATURATE = 1'b1
) (
  input logic              clk,
  input logic              rstn,
  systolic_pe_sat_if.slave bus
);
  localparam int unsigned PROD_W = IFMAP_W + W_W;
  localparam int unsigned SUM_W  = PSUM_W + 1;
  localparam int unsigned PEXT_W = SUM_W - PROD_W;

  localparam logic [PSUM_W-1:0] PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic [PSUM_W-1:0] PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

  if (PSUM_W < PROD_W) begin : g_width_check
    $error("systolic_pe_sat: PSUM_W must be at least IFMAP_W+W_W");
  end

  typedef enum logic [0:0] {NO_WEIGHT = 1'b0, READY = 1'b1} wstate_t;

  wstate_t            state;
  wstate_t            state_nx;
  logic               ready_c;
  logic [W_W-1:0]     shadow;
  logic [W_W-1:0]     active;

  logic signed [PROD_W-1:0] act_x_c;
  logic signed [PROD_W-1:0] ifm_x_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic                     ovf_c;
  logic [PSUM_W-1:0]        result_c;

  // Weight FSM: state register
  always_ff @(posedge clk) begin
    if (!rstn) state <= NO_WEIGHT;
    else       state <= state_nx;
  end

  // Weight FSM: a swap commits the first weight; only reset leaves READY
  always_comb begin
    state_nx = state;
    if (state == NO_WEIGHT && bus.w_swap_in) state_nx = READY;
  end

  // Weight FSM: decoded state
  always_comb begin
    ready_c = 1'b0;
    if (state == READY) ready_c = 1'b1;
  end

  // Full-precision product and one-bit-wider sum; overflow when the top two bits differ
  always_comb begin
    act_x_c  = {{IFMAP_W{active[W_W-1]}}, active};
    ifm_x_c  = {{W_W{bus.ifmap_data_in[IFMAP_W-1]}}, bus.ifmap_data_in};
    prod_c   = act_x_c * ifm_x_c;
    sum_c    = {{PEXT_W{prod_c[PROD_W-1]}}, prod_c}
             + {bus.psum_data_in[PSUM_W-1], bus.psum_data_in};
    ovf_c    = sum_c[SUM_W-1] ^ sum_c[PSUM_W-1];
    result_c = sum_c[PSUM_W-1:0];
    if (SATURATE && ovf_c) result_c = sum_c[SUM_W-1] ? PSUM_MIN : PSUM_MAX;
  end

  // Weight chain; swap copies the pre-load shadow so load+swap commits the old value
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shadow         <= '0;
      active         <= '0;
      bus.w_load_out <= 1'b0;
      bus.w_swap_out <= 1'b0;
    end else begin
      bus.w_load_out <= bus.w_load_in;
      bus.w_swap_out <= bus.w_swap_in;
      if (bus.w_load_in) shadow <= bus.w_data_in;
      if (bus.w_swap_in) active <= shadow;
    end
  end

  assign bus.w_data_out = shadow;

  // Datapath registers; data holds while idle, valids follow the input valid
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.ifmap_valid_out <= 1'b0;
      bus.ifmap_data_out  <= '0;
      bus.psum_valid_out  <= 1'b0;
      bus.psum_data_out   <= '0;
      bus.ovf_sticky      <= 1'b0;
      bus.nw_err          <= 1'b0;
    end else begin
      bus.ifmap_valid_out <= bus.ifmap_valid_in;
      bus.psum_valid_out  <= bus.ifmap_valid_in;
      bus.nw_err          <= bus.ifmap_valid_in && !ready_c;
      if (bus.ifmap_valid_in) begin
        bus.ifmap_data_out <= bus.ifmap_data_in;
        bus.psum_data_out  <= ready_c ? result_c : bus.psum_data_in;
      end
      if (bus.clr_ovf)                                   bus.ovf_sticky <= 1'b0;
      else if (bus.ifmap_valid_in && ready_c && ovf_c)   bus.ovf_sticky <= 1'b1;
    end
  end

  a_no_load_with_ifmap : assert property (@(posedge clk) disable iff (!rstn)
    !(bus.w_load_in && bus.ifmap_valid_in));

  a_psum_valid_latency : assert property (@(posedge clk) disable iff (!rstn)
    $past(rstn) |-> (bus.psum_valid_out == $past(bus.ifmap_valid_in)));

endmodule

// File: tb/tb_systolic_pe_sat.sv
// Bench for systolic_pe_sat: saturating and wrapping instances share stimulus and
// are checked every cycle against an arithmetic model plus literal expectations.
module tb_systolic_pe_sat;
  localparam int unsigned IFMAP_W = 16;
  localparam int unsigned W_W     = 8;
  localparam int unsigned PSUM_W  = 32;
  localparam longint PMAX = 64'sd2147483647;
  localparam longint PMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic                      w_load = 1'b0;
  logic signed [W_W-1:0]     w_data = '0;
  logic                      w_swap = 1'b0;
  logic                      ivalid = 1'b0;
  logic signed [IFMAP_W-1:0] idata  = '0;
  logic signed [PSUM_W-1:0]  psum_in = '0;
  logic                      clr = 1'b0;

  systolic_pe_sat_if #(.IFMAP_W(IFMAP_W), .W_W(W_W), .PSUM_W(PSUM_W)) bus_s ();
  systolic_pe_sat_if #(.IFMAP_W(IFMAP_W), .W_W(W_W), .PSUM_W(PSUM_W)) bus_w ();

  assign bus_s.w_load_in = w_load;   assign bus_w.w_load_in = w_load;
  assign bus_s.w_data_in = w_data;   assign bus_w.w_data_in = w_data;
  assign bus_s.w_swap_in = w_swap;   assign bus_w.w_swap_in = w_swap;
  assign bus_s.ifmap_valid_in = ivalid; assign bus_w.ifmap_valid_in = ivalid;
  assign bus_s.ifmap_data_in  = idata;  assign bus_w.ifmap_data_in  = idata;
  assign bus_s.psum_data_in   = psum_in; assign bus_w.psum_data_in  = psum_in;
  assign bus_s.clr_ovf = clr;        assign bus_w.clr_ovf = clr;

  systolic_pe_sat #(.IFMAP_W(IFMAP_W), .W_W(W_W), .PSUM_W(PSUM_W), .SATURATE(1'b1))
    u_sat (.clk(clk), .rstn(rstn), .bus(bus_s));
  systolic_pe_sat #(.IFMAP_W(IFMAP_W), .W_W(W_W), .PSUM_W(PSUM_W), .SATURATE(1'b0))
    u_wrap (.clk(clk), .rstn(rstn), .bus(bus_w));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the rules, one update per clock
  bit               started = 1'b0;
  longint           m_shadow, m_active, m_prod, m_sum;
  bit               m_ready, m_oor;
  bit               m_wlo, m_wso, m_ivo, m_pvo, m_ovf, m_nw;
  logic [W_W-1:0]   m_wdo;
  logic [IFMAP_W-1:0] m_ido;
  logic [PSUM_W-1:0]  m_pdo_s, m_pdo_w;

  always @(posedge clk) begin
    if (!rstn) begin
      started = 1'b1;
      m_shadow = 0; m_active = 0; m_ready = 1'b0;
      m_wlo = 0; m_wso = 0; m_ivo = 0; m_pvo = 0; m_ovf = 0; m_nw = 0;
      m_wdo = '0; m_ido = '0; m_pdo_s = '0; m_pdo_w = '0;
    end else begin
      m_prod = m_active * longint'(idata);
      m_sum  = m_prod + longint'(psum_in);
      m_oor  = (m_sum > PMAX) || (m_sum < PMIN);
      m_wlo = w_load;
      m_wso = w_swap;
      m_ivo = ivalid;
      m_pvo = ivalid;
      m_nw  = ivalid && !m_ready;
      if (ivalid) begin
        m_ido = idata;
        if (m_ready) begin
          m_pdo_s = 32'(m_sum > PMAX ? PMAX : (m_sum < PMIN ? PMIN : m_sum));
          m_pdo_w = 32'(m_sum);
        end else begin
          m_pdo_s = psum_in;
          m_pdo_w = psum_in;
        end
      end
      if (clr) m_ovf = 1'b0;
      else if (ivalid && m_ready && m_oor) m_ovf = 1'b1;
      if (w_swap) begin
        m_active = m_shadow;
        m_ready  = 1'b1;
      end
      if (w_load) m_shadow = longint'(w_data);
      m_wdo = W_W'(m_shadow);
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (started) begin
      check("sat.w_load_out",  64'(bus_s.w_load_out),  64'(m_wlo));
      check("sat.w_swap_out",  64'(bus_s.w_swap_out),  64'(m_wso));
      check("sat.w_data_out",  64'(bus_s.w_data_out),  64'(m_wdo));
      check("sat.ifmap_valid_out", 64'(bus_s.ifmap_valid_out), 64'(m_ivo));
      check("sat.ifmap_data_out",  64'(bus_s.ifmap_data_out),  64'(m_ido));
      check("sat.psum_valid_out",  64'(bus_s.psum_valid_out),  64'(m_pvo));
      check("sat.psum_data_out",   64'(bus_s.psum_data_out),   64'(m_pdo_s));
      check("sat.ovf_sticky",  64'(bus_s.ovf_sticky),  64'(m_ovf));
      check("sat.nw_err",      64'(bus_s.nw_err),      64'(m_nw));
      check("wrap.w_data_out", 64'(bus_w.w_data_out),  64'(m_wdo));
      check("wrap.psum_valid_out", 64'(bus_w.psum_valid_out), 64'(m_pvo));
      check("wrap.psum_data_out",  64'(bus_w.psum_data_out),  64'(m_pdo_w));
      check("wrap.ifmap_data_out", 64'(bus_w.ifmap_data_out), 64'(m_ido));
      check("wrap.ovf_sticky", 64'(bus_w.ovf_sticky),  64'(m_ovf));
      check("wrap.nw_err",     64'(bus_w.nw_err),      64'(m_nw));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_load = 1'b0; w_swap = 1'b0; ivalid = 1'b0; clr = 1'b0;
  endtask

  task automatic set_weight(input logic signed [W_W-1:0] w);
    idle(); w_load = 1'b1; w_data = w; tick();
    idle(); w_swap = 1'b1; tick();
    idle();
  endtask

  task automatic feed(input logic signed [IFMAP_W-1:0] x, input logic signed [PSUM_W-1:0] p);
    idle(); ivalid = 1'b1; idata = x; psum_in = p; tick();
    idle();
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    check("reset.psum", 64'(bus_s.psum_data_out), 64'h0);
    check("reset.pvalid", 64'(bus_s.psum_valid_out), 64'h0);
    check("reset.nw_err", 64'(bus_s.nw_err), 64'h0);
    check("reset.wdata", 64'(bus_s.w_data_out), 64'h0);

    // No weight committed yet: pass-through with error pulse
    feed(16'sd9, 32'sd42);
    check("nw.psum", 64'(bus_s.psum_data_out), 64'd42);
    check("nw.err", 64'(bus_s.nw_err), 64'd1);
    check("nw.pvalid", 64'(bus_s.psum_valid_out), 64'd1);
    tick();
    check("nw.err_clears", 64'(bus_s.nw_err), 64'd0);
    check("idle.pvalid", 64'(bus_s.psum_valid_out), 64'd0);
    check("idle.hold", 64'(bus_s.psum_data_out), 64'd42);

    set_weight(8'sd3);
    feed(16'sd100, 32'sd5);
    check("basic.psum", 64'(bus_s.psum_data_out), 64'd305);
    check("basic.pvalid", 64'(bus_s.psum_valid_out), 64'd1);
    check("basic.wrap", 64'(bus_w.psum_data_out), 64'd305);

    set_weight(-8'sd128);
    feed(-16'sd32768, 32'sd0);
    check("maxprod.psum", 64'(bus_s.psum_data_out), 64'h0040_0000);
    check("maxprod.ovf", 64'(bus_s.ovf_sticky), 64'd0);

    set_weight(8'sd2);
    feed(16'sd100, 32'sh7FFF_FFF0);
    check("possat.psum", 64'(bus_s.psum_data_out), 64'h7FFF_FFFF);
    check("possat.ovf", 64'(bus_s.ovf_sticky), 64'd1);
    check("poswrap.psum", 64'(bus_w.psum_data_out), 64'h8000_00B8);
    check("poswrap.ovf", 64'(bus_w.ovf_sticky), 64'd1);
    clr = 1'b1; tick(); idle();
    check("clr.ovf", 64'(bus_s.ovf_sticky), 64'd0);
    // clear wins over a simultaneous overflow
    ivalid = 1'b1; idata = 16'sd100; psum_in = 32'sh7FFF_FFF0; clr = 1'b1; tick(); idle();
    check("clrprio.ovf", 64'(bus_s.ovf_sticky), 64'd0);
    check("clrprio.wrap_ovf", 64'(bus_w.ovf_sticky), 64'd0);

    set_weight(-8'sd128);
    feed(16'sd32767, 32'sh8000_0000);
    check("negsat.psum", 64'(bus_s.psum_data_out), 64'h8000_0000);
    check("negwrap.psum", 64'(bus_w.psum_data_out), 64'h7FC0_0080);
    check("negsat.ovf", 64'(bus_s.ovf_sticky), 64'd1);
    clr = 1'b1; tick(); idle();

    // Load and swap together commit the old shadow
    set_weight(8'sd3);
    w_load = 1'b1; w_data = 8'sd7; w_swap = 1'b1; tick(); idle();
    check("ldswap.wdata", 64'(bus_s.w_data_out), 64'd7);
    check("ldswap.swap_out", 64'(bus_s.w_swap_out), 64'd1);
    feed(16'sd10, 32'sd0);
    check("ldswap.old", 64'(bus_s.psum_data_out), 64'd30);
    w_swap = 1'b1; tick(); idle();
    feed(16'sd10, 32'sd0);
    check("ldswap.new", 64'(bus_s.psum_data_out), 64'd70);

    // Swap with ifmap in the same cycle uses the pre-swap weight
    w_load = 1'b1; w_data = 8'sd5; tick(); idle();
    ivalid = 1'b1; idata = 16'sd10; psum_in = 32'sd1; w_swap = 1'b1; tick(); idle();
    check("swapfeed.pre", 64'(bus_s.psum_data_out), 64'd71);
    feed(-16'sd10, 32'sd1);
    check("swapfeed.post", 64'(bus_s.psum_data_out), 64'hFFFF_FFCF);

    // Reset mid-operation drops everything and returns to NO_WEIGHT
    w_load = 1'b1; w_data = 8'sd9; rstn = 1'b0; tick();
    idle(); ivalid = 1'b1; idata = 16'sd4; tick(); idle();
    check("midrst.psum", 64'(bus_s.psum_data_out), 64'd0);
    check("midrst.wdata", 64'(bus_s.w_data_out), 64'd0);
    rstn = 1'b1;
    feed(16'sd4, 32'sd77);
    check("midrst.passthru", 64'(bus_s.psum_data_out), 64'd77);
    check("midrst.nw_err", 64'(bus_s.nw_err), 64'd1);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
